mem_arbiter: RTL and testbench

//  Shares the single-ported burst memory between the instruction-fetch port (I) and the data port (D).

---
 rtl/mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory between instruction fetch (I) and data (D) ports.
// Range-checks each request, issues a one-cycle memory command, then steers returned beats to the winner.
module mem_arbiter #(
  parameter logic [31:0] MEM_BASE   = 32'h8002_0000,
  parameter int unsigned MEM_SIZE   = 1024,
  parameter int unsigned TURNAROUND = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_size,
  output logic        i_ack,
  output logic        i_valid,
  output logic [31:0] i_rdata,
  output logic [31:0] i_pc,
  output logic        i_done,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic        d_rw,
  input  logic [2:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_valid,
  output logic [31:0] d_rdata,
  output logic        err,
  output logic        err_port,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [2:0]  mem_size,
  output logic        mem_rw,
  output logic        mem_enable,
  input  logic [31:0] mem_dout,
  input  logic        mem_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, GAP} state_t;

  localparam logic [32:0] MEM_LAST = {1'b0, MEM_BASE} + 33'(MEM_SIZE) - 33'd1;
  localparam logic [1:0]  GAP_LOAD = (TURNAROUND == 0) ? 2'd0 : 2'(TURNAROUND - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  gap_cnt_q, gap_cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_din_q, mem_din_d;
  logic [2:0]  mem_size_q, mem_size_d;
  logic        mem_rw_q, mem_rw_d;
  logic        mem_enable_q, mem_enable_d;

  logic        pick_d, grant, sel_legal, in_range;
  logic [31:0] sel_addr, rd_ext;
  logic [6:0]  sel_bytes;
  logic [3:0]  sel_last_beat;
  logic [32:0] end_addr;
  logic        unused_mem_busy;

  assign unused_mem_busy = mem_busy;

  // last_grant_q: 1 = D. On a tie the port opposite the last grant wins.
  always_comb begin
    pick_d        = d_req && (!i_req || !last_grant_q);
    grant         = (state_q == IDLE) && (i_req || d_req) && !reset;
    sel_addr      = pick_d ? d_addr : i_addr;
    sel_legal     = 1'b1;
    sel_bytes     = 7'd4;
    sel_last_beat = '0;
    if (pick_d) begin
      case (d_size)
        3'b000:  sel_bytes = 7'd4;
        3'b100:  sel_bytes = 7'd1;
        3'b101:  sel_bytes = 7'd2;
        default: sel_legal = 1'b0;
      endcase
    end else begin
      case (i_size)
        3'b000:  begin sel_bytes = 7'd4;  sel_last_beat = 4'd0;  end
        3'b001:  begin sel_bytes = 7'd16; sel_last_beat = 4'd3;  end
        3'b010:  begin sel_bytes = 7'd32; sel_last_beat = 4'd7;  end
        3'b011:  begin sel_bytes = 7'd64; sel_last_beat = 4'd15; end
        default: sel_legal = 1'b0;
      endcase
    end
    // 33-bit sum so a wrap past 2^32 lands above MEM_LAST and is rejected
    end_addr = {1'b0, sel_addr} + {26'd0, sel_bytes} - 33'd1;
    in_range = sel_legal && (sel_addr >= MEM_BASE) && (end_addr <= MEM_LAST);
  end

  always_comb begin
    case (mem_size_q)
      3'b100:  rd_ext = {24'd0, mem_dout[7:0]};
      3'b101:  rd_ext = {16'd0, mem_dout[15:0]};
      default: rd_ext = mem_dout;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    beat_cnt_d   = beat_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    pc_d         = pc_q;
    d_rdata_d    = d_rdata_q;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    mem_size_d   = mem_size_q;
    mem_rw_d     = mem_rw_q;
    mem_enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          last_grant_d = pick_d;
          if (in_range) begin
            state_d      = ISSUE;
            port_d       = pick_d;
            mem_enable_d = 1'b1;
            mem_addr_d   = sel_addr;
            mem_size_d   = pick_d ? d_size : i_size;
            mem_rw_d     = pick_d && d_rw;
            mem_din_d    = pick_d ? d_wdata : '0;
            beat_cnt_d   = sel_last_beat;
            if (!pick_d) pc_d = i_addr;
          end
        end
      end
      ISSUE: state_d = XFER;
      XFER: begin
        if (port_q && !mem_rw_q) d_rdata_d = rd_ext;
        if (beat_cnt_q == '0) begin
          state_d   = (TURNAROUND == 0) ? IDLE : GAP;
          gap_cnt_d = GAP_LOAD;
        end else begin
          beat_cnt_d = beat_cnt_q - 4'd1;
          if (!port_q) pc_d = pc_q + 32'd4;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = IDLE;
        else gap_cnt_d = gap_cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b0;
      port_q       <= 1'b0;
      beat_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      pc_q         <= '0;
      d_rdata_q    <= '0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      mem_size_q   <= '0;
      mem_rw_q     <= 1'b0;
      mem_enable_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      beat_cnt_q   <= beat_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      pc_q         <= pc_d;
      d_rdata_q    <= d_rdata_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      mem_size_q   <= mem_size_d;
      mem_rw_q     <= mem_rw_d;
      mem_enable_q <= mem_enable_d;
    end
  end

  assign i_ack      = grant && !pick_d;
  assign d_ack      = grant && pick_d;
  assign err        = grant && !in_range;
  assign err_port   = err && pick_d;
  assign i_valid    = (state_q == XFER) && !port_q;
  assign d_valid    = (state_q == XFER) && port_q;
  assign i_done     = i_valid && (beat_cnt_q == '0);
  assign i_rdata    = i_valid ? mem_dout : '0;
  assign i_pc       = pc_q;
  assign d_rdata    = (d_valid && !mem_rw_q) ? rd_ext : d_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_size   = mem_size_q;
  assign mem_rw     = mem_rw_q;
  assign mem_enable = mem_enable_q;

  a_enable_only_in_issue: assert property (@(posedge clk) disable iff (reset)
    mem_enable_q |-> state_q == ISSUE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expectations, a negedge monitor pops and compares.
// Includes a byte-addressed burst memory model returning beat k in the (k+1)-th cycle after enable.
module tb_mem_arbiter;
  localparam logic [31:0] BASE = 32'h8002_0000;

  logic        clk = 1'b0, reset = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_rw = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]  i_size = '0, d_size = '0;
  logic        i_ack, i_valid, i_done, d_ack, d_valid, err, err_port;
  logic [31:0] i_rdata, i_pc, d_rdata, mem_addr, mem_din;
  logic [2:0]  mem_size;
  logic        mem_rw, mem_enable, mem_busy;
  logic [31:0] mem_dout = '0;

  mem_arbiter #(.MEM_BASE(BASE), .MEM_SIZE(1024), .TURNAROUND(1)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_ack(i_ack), .i_valid(i_valid),
    .i_rdata(i_rdata), .i_pc(i_pc), .i_done(i_done),
    .d_req(d_req), .d_addr(d_addr), .d_rw(d_rw), .d_size(d_size), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_valid(d_valid), .d_rdata(d_rdata), .err(err), .err_port(err_port),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_size(mem_size), .mem_rw(mem_rw),
    .mem_enable(mem_enable), .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [31:0] pc; logic [31:0] data; logic done; } ibeat_t;
  typedef struct { logic [31:0] data; } dresp_t;
  typedef struct { logic [31:0] addr; logic [2:0] size; logic rw; logic [31:0] din; } mreq_t;
  ibeat_t     i_q[$];
  dresp_t     d_q[$];
  mreq_t      m_q[$];
  logic [1:0] g_q[$];  // {err, port}; port 1 = D

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- memory model ----------------
  logic [7:0]  mem [0:1023];
  logic [31:0] mm_addr = '0;
  int unsigned mm_left = 0;
  initial for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
  assign mem_busy = (mm_left != 0);

  function automatic int unsigned nbeats(input logic [2:0] s);
    case (s)
      3'b001:  return 4;
      3'b010:  return 8;
      3'b011:  return 16;
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a, input logic [2:0] sz);
    logic [9:0] o;
    o = 10'(a - BASE);
    case (sz)
      3'b100:  return {24'd0, mem[o]};
      3'b101:  return {16'd0, mem[o + 10'd1], mem[o]};
      default: return {mem[o + 10'd3], mem[o + 10'd2], mem[o + 10'd1], mem[o]};
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_enable) begin
      if (mem_rw) begin
        mem[10'(mem_addr - BASE)] <= mem_din[7:0];
        if (mem_size != 3'b100) mem[10'(mem_addr - BASE + 1)] <= mem_din[15:8];
        if (mem_size == 3'b000) begin
          mem[10'(mem_addr - BASE + 2)] <= mem_din[23:16];
          mem[10'(mem_addr - BASE + 3)] <= mem_din[31:24];
        end
        mm_left  <= 0;
        mem_dout <= 32'hDEAD_BEEF;
      end else begin
        mem_dout <= rd(mem_addr, mem_size);
        mm_addr  <= mem_addr + 32'd4;
        mm_left  <= nbeats(mem_size) - 1;
      end
    end else if (mm_left != 0) begin
      mem_dout <= rd(mm_addr, 3'b000);
      mm_addr  <= mm_addr + 32'd4;
      mm_left  <= mm_left - 1;
    end else begin
      mem_dout <= 32'hDEAD_BEEF;
    end
  end

  // ---------------- monitor ----------------
  int ack_cyc = -10, en_cyc = -10, end_cyc = -100, beat_idx = 0;
  initial forever begin
    @(negedge clk);
    if (i_ack || d_ack || err) begin
      if (g_q.size() == 0) fail_now("unexpected_grant");
      else begin
        logic [1:0] g;
        g = g_q.pop_front();
        check("grant", {err, err_port, d_ack, i_ack}, {g[1], g[1] & g[0], g[0], ~g[0]});
        check("turnaround", 64'(cyc - end_cyc > 1), 1);
        if (!err) ack_cyc = cyc;
      end
    end
    if (mem_enable) begin
      if (m_q.size() == 0) fail_now("unexpected_mem_enable");
      else begin
        mreq_t m;
        m = m_q.pop_front();
        check("mem_cmd", {mem_addr, mem_size, mem_rw}, {m.addr, m.size, m.rw});
        check("mem_din", mem_din, m.din);
        check("enable_timing", cyc, ack_cyc + 1);
      end
      en_cyc   = cyc;
      beat_idx = 0;
    end
    if (i_valid) begin
      if (i_q.size() == 0) fail_now("unexpected_i_valid");
      else begin
        ibeat_t b;
        b = i_q.pop_front();
        check("i_beat", {i_pc, i_rdata}, {b.pc, b.data});
        check("i_done", i_done, b.done);
        check("i_beat_timing", cyc, en_cyc + 1 + beat_idx);
      end
      beat_idx++;
      if (i_done) end_cyc = cyc;
    end else if (i_done) fail_now("i_done_without_valid");
    if (d_valid) begin
      if (d_q.size() == 0) fail_now("unexpected_d_valid");
      else begin
        dresp_t r;
        r = d_q.pop_front();
        check("d_rdata", d_rdata, r.data);
        check("d_timing", cyc, en_cyc + 1);
      end
      end_cyc = cyc;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic exp_i(input logic [31:0] a, input logic [2:0] s, input logic [31:0] w0,
                       input int unsigned nexp, input logic is_err);
    g_q.push_back({is_err, 1'b0});
    if (!is_err) begin
      m_q.push_back('{addr: a, size: s, rw: 1'b0, din: 32'd0});
      for (int unsigned k = 0; k < nexp; k++)
        i_q.push_back('{pc: a + 4 * k, data: w0 + 32'h0404_0404 * k, done: (k == nbeats(s) - 1)});
    end
  endtask

  task automatic exp_d(input logic [31:0] a, input logic [2:0] s, input logic rw,
                       input logic [31:0] wd, input logic [31:0] data, input logic is_err);
    g_q.push_back({is_err, 1'b1});
    if (!is_err) begin
      m_q.push_back('{addr: a, size: s, rw: rw, din: wd});
      d_q.push_back('{data: data});
    end
  endtask

  task automatic req_i(input logic [31:0] a, input logic [2:0] s);
    int n = 0;
    @(posedge clk); #1;
    i_req = 1'b1; i_addr = a; i_size = s;
    do begin @(negedge clk); n++; end while (!i_ack && n < 100);
    if (!i_ack) fail_now("i_ack_timeout");
    @(posedge clk); #1;
    i_req = 1'b0;
  endtask

  task automatic req_d(input logic [31:0] a, input logic [2:0] s, input logic rw, input logic [31:0] wd);
    int n = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_addr = a; d_size = s; d_rw = rw; d_wdata = wd;
    do begin @(negedge clk); n++; end while (!d_ack && n < 100);
    if (!d_ack) fail_now("d_ack_timeout");
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic settle();
    repeat (25) @(posedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {i_ack, d_ack, err, err_port, i_valid, i_done, d_valid,
                           mem_enable, mem_rw, mem_size}, '0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_mem_din"}, mem_din, '0);
    check({tag, "_i_pc"}, i_pc, '0);
    check({tag, "_i_rdata"}, i_rdata, '0);
    check({tag, "_d_rdata"}, d_rdata, '0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // 4-word fetch from the base address
    exp_i(BASE, 3'b001, 32'h0302_0100, 4, 1'b0);
    req_i(BASE, 3'b001);
    settle();

    // Tie after reset goes to D, then I after the gap
    do_reset();
    exp_d(BASE + 32'h10, 3'b000, 1'b0, 32'd0, 32'h1312_1110, 1'b0);
    exp_i(BASE + 32'h20, 3'b000, 32'h2322_2120, 1, 1'b0);
    fork
      req_i(BASE + 32'h20, 3'b000);
      req_d(BASE + 32'h10, 3'b000, 1'b0, 32'd0);
    join
    settle();
    exp_d(BASE + 32'h30, 3'b101, 1'b0, 32'd0, 32'h0000_3130, 1'b0);
    req_d(BASE + 32'h30, 3'b101, 1'b0, 32'd0);
    settle();
    // last grant was D, so I wins this tie
    exp_i(BASE + 32'h40, 3'b000, 32'h4342_4140, 1, 1'b0);
    exp_d(BASE + 32'h51, 3'b100, 1'b0, 32'd0, 32'h0000_0051, 1'b0);
    fork
      req_i(BASE + 32'h40, 3'b000);
      req_d(BASE + 32'h51, 3'b100, 1'b0, 32'd0);
    join
    settle();

    // Byte write then reads of the same location
    exp_d(BASE + 32'h103, 3'b100, 1'b1, 32'h1234_56A5, 32'h0000_0051, 1'b0);
    req_d(BASE + 32'h103, 3'b100, 1'b1, 32'h1234_56A5);
    settle();
    exp_d(BASE + 32'h103, 3'b100, 1'b0, 32'd0, 32'h0000_00A5, 1'b0);
    req_d(BASE + 32'h103, 3'b100, 1'b0, 32'd0);
    settle();
    exp_d(BASE + 32'h100, 3'b000, 1'b0, 32'd0, 32'hA502_0100, 1'b0);
    req_d(BASE + 32'h100, 3'b000, 1'b0, 32'd0);
    settle();
    exp_d(BASE + 32'h102, 3'b101, 1'b0, 32'd0, 32'h0000_A502, 1'b0);
    req_d(BASE + 32'h102, 3'b101, 1'b0, 32'd0);
    settle();

    // Upper boundary: last word ok, straddling word rejected
    exp_d(BASE + 32'h3FC, 3'b000, 1'b0, 32'd0, 32'hFFFE_FDFC, 1'b0);
    req_d(BASE + 32'h3FC, 3'b000, 1'b0, 32'd0);
    settle();
    exp_d(BASE + 32'h3FE, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1);
    req_d(BASE + 32'h3FE, 3'b000, 1'b0, 32'd0);
    settle();

    // Rejections: burst past end, bad sizes, below base, 32-bit wrap
    exp_i(BASE + 32'h3C4, 3'b011, 32'd0, 0, 1'b1);
    req_i(BASE + 32'h3C4, 3'b011);
    settle();
    exp_i(BASE, 3'b100, 32'd0, 0, 1'b1);
    req_i(BASE, 3'b100);
    settle();
    exp_d(BASE, 3'b010, 1'b0, 32'd0, 32'd0, 1'b1);
    req_d(BASE, 3'b010, 1'b0, 32'd0);
    settle();
    exp_d(32'h8001_FFFC, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1);
    req_d(32'h8001_FFFC, 3'b000, 1'b0, 32'd0);
    settle();
    exp_d(32'hFFFF_FFFE, 3'b000, 1'b0, 32'd0, 32'd0, 1'b1);
    req_d(32'hFFFF_FFFE, 3'b000, 1'b0, 32'd0);
    settle();

    // Reset during the 3rd beat of a 16-beat fetch
    exp_i(BASE + 32'h3C0, 3'b011, 32'hC3C2_C1C0, 3, 1'b0);
    req_i(BASE + 32'h3C0, 3'b011);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midburst");
    settle();
    exp_i(BASE + 32'h40, 3'b000, 32'h4342_4140, 1, 1'b0);
    req_i(BASE + 32'h40, 3'b000);
    settle();

    check("leftover_grants", g_q.size(), 0);
    check("leftover_mem_cmds", m_q.size(), 0);
    check("leftover_i_beats", i_q.size(), 0);
    check("leftover_d_resps", d_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
